map_irq_scan: RTL and testbench
===============================

// Module: map_irq_scan
// PURPOSE
//  Parametrised scanline/cycle IRQ counter for NES mappers; successor to the fixed 16-bit A12 down-counter.
//  Detects filtered PPU A12 rising edges, or counts raw M2 cycles, and raises a level IRQ to the CPU.
//  Three modes: down-count-and-stop, MMC3-style reload, and auto-repeat cycle timer.
//  Sits beside the bank registers in a map_xxx top; the CPU decode and the save-state port both drive it.
// PARAMETERS
//  CNT_W     16  counter/latch width, legal 8..16
//  FILT_LEN  4   number of consecutive A12-low samples required before a high sample counts, legal 1..7
//  MODE_RST  0   mode value loaded at reset
// PORTS
//  m2         in   1      CPU M2; all state updates on negedge m2
//  map_rst_n  in   1      async active-low reset
//  ppu_a12    in   1      PPU address bit 12, sampled on negedge m2
//  reg_we     in   1      CPU register write strobe, already qualified by the mapper's address decode
//  reg_addr   in   3      register select
//  reg_din    in   8      CPU write data
//  ss_act     in   1      save-state access active; freezes counting and ignores reg_we
//  ss_we      in   1      save-state write strobe, valid only while ss_act
//  ss_addr    in   3      save-state register index
//  ss_din     in   8      save-state write data
//  ss_dout    out  8      save-state read data, combinational
//  irq        out  1      IRQ request, active high; equals pend
// BEHAVIOUR
//  Reset (async, map_rst_n=0): cnt=0, latch=0, mode=MODE_RST, en=0, pend=0, reload=0, filt=0. irq=0.
//  Filter: filt[FILT_LEN:0] <= {filt[FILT_LEN-1:0], ppu_a12} every negedge m2, including while ss_act.
//   a12_ev = filt[0]==1 && filt[FILT_LEN:1]==0, evaluated on the pre-shift value.
//   Result: the edge registers one m2 after the first high sample.
//  Event source: ev = a12_ev in modes 0/1; ev = 1 on every m2 in mode 2; ev is forced to 0 while ss_act.
//  CPU registers (reg_we=1, ss_act=0):
//   0: latch[7:0]=din; in mode 0 also cnt[7:0]=din.
//   1: latch[CNT_W-1:8]=din; in mode 0 also cnt[CNT_W-1:8]. Ignored when CNT_W=8.
//   2: mode=din[1:0]. Mode 3 is reserved and behaves as mode 0.
//   3: en=0, pend=0 (disable + acknowledge).
//   4: en=1.
//   5: mode 1 sets reload=1; modes 0/2 set cnt=latch.
//   6, 7: no effect.
//  Mode 0 (DOWN_STOP), on ev:
//   if cnt!=0 then cnt--; if cnt==1 && en then pend=1.
//   cnt==0 holds with no IRQ.
//  Mode 1 (RELOAD), on ev:
//   nxt = (cnt==0 || reload) ? latch : cnt-1; cnt=nxt; reload=0.
//   if nxt==0 && en then pend=1. With latch=0 and en=1, every event asserts IRQ.
//  Mode 2 (CYCLE), on ev:
//   if cnt==1 then {cnt=latch; pend|=en}; else if cnt!=0 then cnt--.
//   Period = latch m2 cycles; cnt==0 stalls until reloaded.
//  Same-cycle priority:
//   reg write to cnt/latch/reload beats ev; the written value is used and no decrement happens that cycle.
//   Ack (reg 3) beats pend set.
//   en=0 never clears pend; only reg 3 clears it.
//   Writes to regs 0/1/2/4/5 do not change pend.
//  Arithmetic: all counting is modulo 2^CNT_W unsigned. The decrement never underflows because of the cnt!=0 guards.
//  Save state (ss_act=1):
//   CPU writes are ignored; counting halts; the filter keeps sampling.
//   ss_we writes the selected field on negedge m2. ss_dout reads the same map; undefined indices return 8'hFF.
//   Map: 0 cnt[7:0]; 1 cnt[15:8] (zero-padded); 2 latch[7:0]; 3 latch[15:8];
//   4 {3'b0, mode[1:0], reload, pend, en}; 5 {FILT_LEN-wide filt, zero-padded}.
//   On ss_act falling, counting resumes with restored state; no spurious event is produced by the restored filt alone.
//  Reset mid-operation clears pend immediately; irq drops asynchronously.
// TESTING
//  T1 mode 0:
//   write reg0=3, reg1=0, reg4; drive 3 A12 pulses (4 low m2, 1 high) -> cnt 2,1,0.
//   irq rises on the 2nd pulse (cnt 2->1). A 4th pulse leaves cnt=0.
//  T2 filter:
//   A12 high after only 3 low samples (FILT_LEN=4) -> no decrement.
//   A12 held high 10 cycles -> exactly one event.
//  T3 mode 1:
//   reg2=1, reg0=2, reg5, reg4; 7 events -> cnt 2,1,0,2,1,0,2.
//   irq after events 3 and 6, each cleared by reg3 and re-armed with reg4.
//  T4 mode 2:
//   reg2=2, reg0=5, reg5, reg4 -> irq asserted 5 m2 after the reg5 write, and every 5 m2 after that with pend held until ack.
//  T5 collisions:
//   reg3 write in the same m2 as the pend-setting event -> irq stays 0.
//   reg0 write concurrent with ev in mode 0 -> cnt equals the written value.
//  T6 save/restore + reset:
//   in mode 1 with cnt=0x1234, CNT_W=16: read ss 0..5, reset, write back via ss_we, drop ss_act.
//   Next events continue 0x1233, 0x1232.
//   map_rst_n pulsed with irq=1 -> irq=0 with no m2 edge.

Source files
------------

// File: rtl/map_irq_scan_if.sv
// CPU register port and save-state port of the scanline/cycle IRQ counter.
interface map_irq_scan_if;
  logic       reg_we;
  logic [2:0] reg_addr;
  logic [7:0] reg_din;
  logic       ss_act;
  logic       ss_we;
  logic [2:0] ss_addr;
  logic [7:0] ss_din;
  logic [7:0] ss_dout;

  // Mapper decode / save-state controller side
  modport master (
    output reg_we, reg_addr, reg_din,
    output ss_act, ss_we, ss_addr, ss_din,
    input  ss_dout
  );

  // IRQ counter side
  modport slave (
    input  reg_we, reg_addr, reg_din,
    input  ss_act, ss_we, ss_addr, ss_din,
    output ss_dout
  );
endinterface

// File: rtl/map_irq_scan.sv
// Scanline / M2-cycle IRQ counter for NES mappers.
// Counts filtered PPU A12 rising edges (modes 0/1) or raw M2 cycles (mode 2)
// and holds a level IRQ until the CPU acknowledges it. All state advances on
// the falling edge of M2; the save-state port can freeze, dump and restore it.
module map_irq_scan #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned MODE_RST = 0
) (
  input  logic                 m2,
  input  logic                 map_rst_n,
  input  logic                 ppu_a12,
  map_irq_scan_if.slave        bus,
  output logic                 irq
);

  localparam int unsigned FILT_W = FILT_LEN + 1;

  localparam logic [2:0] REG_LATCH_LO = 3'd0;
  localparam logic [2:0] REG_LATCH_HI = 3'd1;
  localparam logic [2:0] REG_MODE     = 3'd2;
  localparam logic [2:0] REG_ACK      = 3'd3;
  localparam logic [2:0] REG_ENABLE   = 3'd4;
  localparam logic [2:0] REG_RELOAD   = 3'd5;

  localparam logic [2:0] SS_CNT_LO   = 3'd0;
  localparam logic [2:0] SS_CNT_HI   = 3'd1;
  localparam logic [2:0] SS_LATCH_LO = 3'd2;
  localparam logic [2:0] SS_LATCH_HI = 3'd3;
  localparam logic [2:0] SS_CTRL     = 3'd4;
  localparam logic [2:0] SS_FILT     = 3'd5;

  typedef enum logic [1:0] {
    MODE_DOWN   = 2'd0,
    MODE_RELOAD = 2'd1,
    MODE_CYCLE  = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  localparam logic [1:0] MODE_RST_L = 2'(MODE_RST);

  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [CNT_W-1:0]  latch_q,  latch_d;
  mode_t             mode_q,   mode_d;
  logic              en_q,     en_d;
  logic              pend_q,   pend_d;
  logic              reload_q, reload_d;
  logic [FILT_W-1:0] filt_q,   filt_d;

  logic              a12_ev;
  logic              ev;
  logic              cpu_we;
  logic              cnt_wr;
  logic              down_like;
  logic              pend_set;
  logic [CNT_W-1:0]  nxt;
  logic [7:0]        ss_dout_c;

  // Replace the low byte of a counter-width value
  function automatic logic [CNT_W-1:0] set_lo(input logic [CNT_W-1:0] v,
                                               input logic [7:0] b);
    logic [15:0] w;
    w       = 16'(v);
    w[7:0]  = b;
    return CNT_W'(w);
  endfunction

  // Replace the high byte; no effect when the counter is only 8 bits wide
  function automatic logic [CNT_W-1:0] set_hi(input logic [CNT_W-1:0] v,
                                               input logic [7:0] b);
    logic [15:0] w;
    w       = 16'(v);
    w[15:8] = b;
    return CNT_W'(w);
  endfunction

  // Byte views of a counter-width value, zero-padded to 16 bits
  function automatic logic [7:0] get_lo(input logic [CNT_W-1:0] v);
    logic [15:0] w;
    w = 16'(v);
    return w[7:0];
  endfunction

  function automatic logic [7:0] get_hi(input logic [CNT_W-1:0] v);
    logic [15:0] w;
    w = 16'(v);
    return w[15:8];
  endfunction

  // Rising A12 after FILT_LEN low samples, judged on the pre-shift history
  assign a12_ev    = filt_q[0] && (filt_q[FILT_LEN:1] == '0);

  // Mode 3 is reserved and decodes like mode 0
  assign down_like = (mode_q == MODE_DOWN) || (mode_q == MODE_RSVD);

  // Count source; save-state access freezes counting
  assign ev        = !bus.ss_act && ((mode_q == MODE_CYCLE) ? 1'b1 : a12_ev);

  // CPU writes are blocked during save-state access
  assign cpu_we    = bus.reg_we && !bus.ss_act;

  // A CPU write touching cnt/latch/reload pre-empts this cycle's count
  assign cnt_wr    = cpu_we && ((bus.reg_addr == REG_LATCH_LO) ||
                                (bus.reg_addr == REG_LATCH_HI) ||
                                (bus.reg_addr == REG_RELOAD));

  // State register, advanced on the falling edge of M2
  always_ff @(negedge m2 or negedge map_rst_n) begin
    if (!map_rst_n) begin
      cnt_q    <= '0;
      latch_q  <= '0;
      mode_q   <= mode_t'(MODE_RST_L);
      en_q     <= 1'b0;
      pend_q   <= 1'b0;
      reload_q <= 1'b0;
      filt_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      latch_q  <= latch_d;
      mode_q   <= mode_d;
      en_q     <= en_d;
      pend_q   <= pend_d;
      reload_q <= reload_d;
      filt_q   <= filt_d;
    end
  end

  // Next state: count, then CPU writes, then ack, then save-state writes
  always_comb begin
    cnt_d    = cnt_q;
    latch_d  = latch_q;
    mode_d   = mode_q;
    en_d     = en_q;
    pend_d   = pend_q;
    reload_d = reload_q;
    filt_d   = {filt_q[FILT_LEN-1:0], ppu_a12};
    nxt      = '0;
    pend_set = 1'b0;

    if (ev && !cnt_wr) begin
      case (mode_q)
        MODE_RELOAD: begin
          nxt      = ((cnt_q == '0) || reload_q) ? latch_q : cnt_q - CNT_W'(1);
          cnt_d    = nxt;
          reload_d = 1'b0;
          pend_set = en_q && (nxt == '0);
        end
        MODE_CYCLE: begin
          if (cnt_q == CNT_W'(1)) begin
            cnt_d    = latch_q;
            pend_set = en_q;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          // Down-and-stop: IRQ fires as the counter reaches 1
          if (cnt_q != '0) begin
            cnt_d    = cnt_q - CNT_W'(1);
            pend_set = en_q && (cnt_q == CNT_W'(2));
          end
        end
      endcase
    end

    if (pend_set) begin
      pend_d = 1'b1;
    end

    if (cpu_we) begin
      case (bus.reg_addr)
        REG_LATCH_LO: begin
          latch_d = set_lo(latch_q, bus.reg_din);
          if (down_like) begin
            cnt_d = set_lo(cnt_q, bus.reg_din);
          end
        end
        REG_LATCH_HI: begin
          latch_d = set_hi(latch_q, bus.reg_din);
          if (down_like) begin
            cnt_d = set_hi(cnt_q, bus.reg_din);
          end
        end
        REG_MODE: begin
          mode_d = mode_t'(bus.reg_din[1:0]);
        end
        REG_ACK: begin
          // Acknowledge outranks a same-cycle pend set
          en_d   = 1'b0;
          pend_d = 1'b0;
        end
        REG_ENABLE: begin
          en_d = 1'b1;
        end
        REG_RELOAD: begin
          if (mode_q == MODE_RELOAD) begin
            reload_d = 1'b1;
          end else begin
            cnt_d = latch_q;
          end
        end
        default: begin
        end
      endcase
    end

    if (bus.ss_act && bus.ss_we) begin
      case (bus.ss_addr)
        SS_CNT_LO:   cnt_d   = set_lo(cnt_q, bus.ss_din);
        SS_CNT_HI:   cnt_d   = set_hi(cnt_q, bus.ss_din);
        SS_LATCH_LO: latch_d = set_lo(latch_q, bus.ss_din);
        SS_LATCH_HI: latch_d = set_hi(latch_q, bus.ss_din);
        SS_CTRL: begin
          mode_d   = mode_t'(bus.ss_din[4:3]);
          reload_d = bus.ss_din[2];
          pend_d   = bus.ss_din[1];
          en_d     = bus.ss_din[0];
        end
        SS_FILT: begin
          // Oldest sample is not saved; restore it as high so a restored
          // history can never form an edge on its own
          filt_d = {1'b1, bus.ss_din[FILT_LEN-1:0]};
        end
        default: begin
        end
      endcase
    end
  end

  // Save-state read map
  always_comb begin
    ss_dout_c = 8'hFF;
    case (bus.ss_addr)
      SS_CNT_LO:   ss_dout_c = get_lo(cnt_q);
      SS_CNT_HI:   ss_dout_c = get_hi(cnt_q);
      SS_LATCH_LO: ss_dout_c = get_lo(latch_q);
      SS_LATCH_HI: ss_dout_c = get_hi(latch_q);
      SS_CTRL:     ss_dout_c = {3'b000, mode_q, reload_q, pend_q, en_q};
      SS_FILT:     ss_dout_c = 8'(filt_q[FILT_LEN-1:0]);
      default:     ss_dout_c = 8'hFF;
    endcase
  end

  assign bus.ss_dout = ss_dout_c;
  assign irq         = pend_q;

endmodule

// File: tb/tb_map_irq_scan.sv
// Directed bench for map_irq_scan (CNT_W=16, FILT_LEN=4, MODE_RST=0).
module tb_map_irq_scan;

  logic m2;
  logic map_rst_n;
  logic ppu_a12;
  logic irq;

  int vectors;
  int miscompares;

  logic [15:0] t3_exp [7];

  map_irq_scan_if bus ();

  map_irq_scan #(
    .CNT_W    (16),
    .FILT_LEN (4),
    .MODE_RST (0)
  ) dut (
    .m2        (m2),
    .map_rst_n (map_rst_n),
    .ppu_a12   (ppu_a12),
    .bus       (bus),
    .irq       (irq)
  );

  // M2 clock, 10 time units per cycle
  initial m2 = 1'b0;
  always #5 m2 = ~m2;

  // Single comparison point
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    check(tag, 16'(irq), 16'(exp));
  endtask

  task automatic chk_ss(input string tag, input logic [2:0] idx, input logic [7:0] exp);
    bus.ss_addr = idx;
    #1;
    check(tag, 16'(bus.ss_dout), 16'(exp));
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] exp);
    logic [7:0] lo;
    logic [7:0] hi;
    bus.ss_addr = 3'd0;
    #1;
    lo = bus.ss_dout;
    bus.ss_addr = 3'd1;
    #1;
    hi = bus.ss_dout;
    check(tag, {hi, lo}, exp);
  endtask

  // One M2 cycle with the given A12 level and optional CPU write
  task automatic cyc(input logic a12, input logic we, input logic [2:0] addr, input logic [7:0] din);
    ppu_a12      = a12;
    bus.reg_we   = we;
    bus.reg_addr = addr;
    bus.reg_din  = din;
    @(negedge m2);
    #1;
    bus.reg_we   = 1'b0;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [7:0] din);
    cyc(1'b0, 1'b1, addr, din);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  // One high sample followed by four lows; the edge lands on the first low
  task automatic pulse();
    cyc(1'b1, 1'b0, 3'd0, 8'h00);
    idle(4);
  endtask

  task automatic sswr(input logic [2:0] idx, input logic [7:0] din);
    ppu_a12     = 1'b0;
    bus.ss_we   = 1'b1;
    bus.ss_addr = idx;
    bus.ss_din  = din;
    @(negedge m2);
    #1;
    bus.ss_we   = 1'b0;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    t3_exp       = '{16'd2, 16'd1, 16'd0, 16'd2, 16'd1, 16'd0, 16'd2};
    map_rst_n    = 1'b0;
    ppu_a12      = 1'b0;
    bus.reg_we   = 1'b0;
    bus.reg_addr = 3'd0;
    bus.reg_din  = 8'h00;
    bus.ss_act   = 1'b0;
    bus.ss_we    = 1'b0;
    bus.ss_addr  = 3'd0;
    bus.ss_din   = 8'h00;
    #12;
    map_rst_n = 1'b1;

    // Reset state
    chk_irq("rst_irq", 1'b0);
    chk_cnt("rst_cnt", 16'h0000);
    chk_ss("rst_ctrl", 3'd4, 8'h00);
    chk_ss("rst_bad_idx", 3'd7, 8'hFF);

    // T1: mode 0 down-and-stop
    wr(3'd0, 8'd3);
    wr(3'd1, 8'd0);
    wr(3'd4, 8'd0);
    chk_cnt("t1_load", 16'd3);
    pulse();
    chk_cnt("t1_cnt_p1", 16'd2);
    chk_irq("t1_irq_p1", 1'b0);
    pulse();
    chk_cnt("t1_cnt_p2", 16'd1);
    chk_irq("t1_irq_p2", 1'b1);
    pulse();
    chk_cnt("t1_cnt_p3", 16'd0);
    chk_irq("t1_irq_p3", 1'b1);
    pulse();
    chk_cnt("t1_hold_zero", 16'd0);

    // T2: A12 filter
    wr(3'd3, 8'd0);
    chk_irq("t2_ack", 1'b0);
    wr(3'd0, 8'd9);
    cyc(1'b1, 1'b0, 3'd0, 8'h00);
    idle(3);
    cyc(1'b1, 1'b0, 3'd0, 8'h00);
    idle(4);
    chk_cnt("t2_short_low", 16'd8);
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b0, 3'd0, 8'h00);
    idle(4);
    chk_cnt("t2_held_high", 16'd7);
    chk_irq("t2_irq", 1'b0);

    // T3: mode 1 reload
    wr(3'd2, 8'd1);
    wr(3'd0, 8'd2);
    wr(3'd5, 8'd0);
    wr(3'd4, 8'd0);
    for (int i = 0; i < 7; i++) begin
      pulse();
      chk_cnt("t3_cnt", t3_exp[i]);
      chk_irq("t3_irq", (i == 2) || (i == 5));
      if ((i == 2) || (i == 5)) begin
        wr(3'd3, 8'd0);
        chk_irq("t3_ack", 1'b0);
        wr(3'd4, 8'd0);
      end
    end

    // T4: mode 2 cycle timer
    wr(3'd3, 8'd0);
    wr(3'd2, 8'd2);
    wr(3'd0, 8'd5);
    chk_cnt("t4_latch_wr_no_dec", 16'd2);
    wr(3'd5, 8'd0);
    chk_cnt("t4_reload", 16'd5);
    wr(3'd4, 8'd0);
    idle(3);
    chk_irq("t4_irq_early", 1'b0);
    idle(1);
    chk_irq("t4_irq_5cyc", 1'b1);
    chk_cnt("t4_cnt_wrap", 16'd5);
    idle(5);
    chk_irq("t4_pend_held", 1'b1);
    chk_cnt("t4_cnt_wrap2", 16'd5);
    wr(3'd3, 8'd0);
    chk_irq("t4_ack", 1'b0);
    wr(3'd4, 8'd0);
    idle(2);
    chk_irq("t4_irq_before", 1'b0);
    idle(1);
    chk_irq("t4_irq_period", 1'b1);

    // T5: same-cycle collisions
    wr(3'd3, 8'd0);
    wr(3'd4, 8'd0);
    idle(2);
    chk_cnt("t5_cnt_one", 16'd1);
    wr(3'd3, 8'd0);
    chk_irq("t5_ack_beats_set", 1'b0);
    chk_cnt("t5_cnt_reload", 16'd5);
    wr(3'd2, 8'd0);
    chk_cnt("t5_mode0_cnt", 16'd4);
    cyc(1'b1, 1'b0, 3'd0, 8'h00);
    cyc(1'b0, 1'b1, 3'd0, 8'h40);
    chk_cnt("t5_wr_beats_ev", 16'h0040);
    idle(3);
    pulse();
    chk_cnt("t5_after_wr", 16'h003F);

    // T6: save / reset / restore
    wr(3'd2, 8'd1);
    wr(3'd0, 8'h34);
    wr(3'd1, 8'h12);
    wr(3'd5, 8'd0);
    wr(3'd4, 8'd0);
    pulse();
    chk_cnt("t6_cnt", 16'h1234);
    bus.ss_act = 1'b1;
    pulse();
    chk_cnt("t6_frozen", 16'h1234);
    wr(3'd0, 8'h77);
    chk_ss("t6_ss0", 3'd0, 8'h34);
    chk_ss("t6_ss1", 3'd1, 8'h12);
    chk_ss("t6_ss2", 3'd2, 8'h34);
    chk_ss("t6_ss3", 3'd3, 8'h12);
    chk_ss("t6_ss4", 3'd4, 8'h09);
    chk_ss("t6_ss5", 3'd5, 8'h00);
    chk_ss("t6_ss6", 3'd6, 8'hFF);
    map_rst_n = 1'b0;
    #1;
    map_rst_n = 1'b1;
    chk_cnt("t6_rst_cnt", 16'h0000);
    chk_ss("t6_rst_latch", 3'd2, 8'h00);
    chk_ss("t6_rst_ctrl", 3'd4, 8'h00);
    sswr(3'd0, 8'h34);
    sswr(3'd1, 8'h12);
    sswr(3'd2, 8'h34);
    sswr(3'd3, 8'h12);
    sswr(3'd4, 8'h09);
    sswr(3'd5, 8'h00);
    chk_cnt("t6_restored_cnt", 16'h1234);
    chk_ss("t6_restored_ctrl", 3'd4, 8'h09);
    bus.ss_act = 1'b0;
    idle(4);
    chk_cnt("t6_no_spurious", 16'h1234);
    pulse();
    chk_cnt("t6_resume1", 16'h1233);
    pulse();
    chk_cnt("t6_resume2", 16'h1232);
    chk_irq("t6_irq", 1'b0);

    // Async reset with IRQ pending
    wr(3'd0, 8'h00);
    wr(3'd1, 8'h00);
    wr(3'd5, 8'd0);
    pulse();
    chk_irq("rst_pre_irq", 1'b1);
    chk_cnt("rst_pre_cnt", 16'h0000);
    map_rst_n = 1'b0;
    #1;
    chk_irq("rst_async_irq", 1'b0);
    #1;
    map_rst_n = 1'b1;
    idle(2);
    chk_irq("rst_post_irq", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
